// File: rtl/dma_peripheral_port.sv
// dma_peripheral_port: device-side DMA channel endpoint with a byte FIFO between peripheral and system bus
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   enable, dir           channel arm and direction (1 = device-to-memory via IOR, 0 = memory-to-device via IOW)
//   dreq, dack_n          DMA request out, acknowledge in
//   ior_n, iow_n, eop_n   bus read/write strobes and end-of-process
//   db_in, db_out, db_oe  system data bus
//   dev_w*, dev_r*        peripheral push/pop handshakes
//   level, tc, err        FIFO occupancy, terminal-count pulse, sticky over/underflow
module dma_peripheral_port #(
    parameter int DEPTH = 8,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          dir,
    output logic          dreq,
    input  logic          dack_n,
    input  logic          ior_n,
    input  logic          iow_n,
    input  logic          eop_n,
    input  logic [7:0]    db_in,
    output logic [7:0]    db_out,
    output logic          db_oe,
    input  logic [7:0]    dev_wdata,
    input  logic          dev_wvalid,
    output logic          dev_wready,
    output logic [7:0]    dev_rdata,
    output logic          dev_rvalid,
    input  logic          dev_rready,
    output logic [LW-1:0] level,
    output logic          tc,
    output logic          err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state, nstate;
    logic          dir_q, ior_q, iow_q, eop_pend, rd_empty;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] cnt, cnt_n;
    logic          strb, strb_q, fall, full, empty, eop_now, done_req;
    logic          flush, load, bus_pop, bus_push, err_set;
    logic          dev_push, dev_pop, push, pop, dir_eff, inflight, dreq_n;

    // Only the strobe for the latched direction matters; its falling edge starts a transfer.
    assign strb     = dir_q ? ior_n : iow_n;
    assign strb_q   = dir_q ? ior_q : iow_q;
    assign fall     = strb_q & ~strb;
    assign full     = cnt == LW'(DEPTH);
    assign empty    = cnt == '0;
    assign eop_now  = ~eop_n & ~dack_n & (state == ARMED || state == STROBE);
    assign done_req = eop_pend | eop_now;

    assign dev_wready = state != IDLE && dir_q && !full;
    assign dev_rvalid = state != IDLE && !dir_q && !empty;
    assign dev_rdata  = mem[rptr];
    assign dev_push   = dev_wvalid & dev_wready;
    assign dev_pop    = dev_rvalid & dev_rready;
    assign level      = cnt;

    always_comb begin
        nstate   = state;
        flush    = 1'b0;
        load     = 1'b0;
        bus_pop  = 1'b0;
        bus_push = 1'b0;
        err_set  = 1'b0;
        if (!enable)
            nstate = IDLE;
        else if (state == IDLE) begin
            nstate = ARMED;
            flush  = 1'b1;
        end else if (state == ARMED) begin
            if (!dack_n && fall) begin
                nstate  = STROBE;
                load    = dir_q;
                err_set = dir_q && empty;
            end else if (done_req)
                nstate = DONE;
        end else if (state == STROBE) begin
            // End of strobe completes the transfer; DACK going away first aborts it.
            if (strb) begin
                nstate   = done_req ? DONE : ARMED;
                bus_pop  = dir_q && !rd_empty;
                bus_push = !dir_q && !full;
                err_set  = !dir_q && full;
            end else if (dack_n)
                nstate = done_req ? DONE : ARMED;
        end
    end

    assign push  = dev_push | bus_push;
    assign pop   = dev_pop | bus_pop;
    assign cnt_n = flush ? '0 : cnt + LW'(push) - LW'(pop);

    // Request lookahead: a transfer still in STROBE is counted as already done,
    // so the controller never sees a request the FIFO cannot honour.
    assign dir_eff  = state == IDLE ? dir : dir_q;
    assign inflight = nstate == STROBE;
    assign dreq_n   = (nstate == ARMED || nstate == STROBE) &&
                      (dir_eff ? cnt_n > LW'(inflight) : cnt_n + LW'(inflight) < LW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= dir_q ? dev_wdata : db_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dir_q    <= 1'b0;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            eop_pend <= 1'b0;
            rd_empty <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            dreq     <= 1'b0;
            db_out   <= 8'h00;
            db_oe    <= 1'b0;
            tc       <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= nstate;
            ior_q    <= ior_n;
            iow_q    <= iow_n;
            if (state == IDLE)
                dir_q <= dir;
            eop_pend <= state != IDLE && done_req;
            wptr     <= flush ? '0 : wptr + AW'(push);
            rptr     <= flush ? '0 : rptr + AW'(pop);
            cnt      <= cnt_n;
            dreq     <= dreq_n;
            db_oe    <= nstate == STROBE && dir_q;
            // Remember an empty read so a device push during the strobe is not popped unseen.
            if (load) begin
                db_out   <= empty ? 8'hFF : mem[rptr];
                rd_empty <= empty;
            end
            tc       <= nstate == DONE && state != DONE;
            err      <= state != IDLE && (err | err_set);
        end
    end
endmodule
